// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state type,
// forwarding-select encodings, the default memory-wait tolerance and a
// register-match helper used by both the forwarding and load-use logic.
package pipe_pkg;

    // Memory-wait supervisor states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Consecutive memory-wait cycles tolerated before giving up
    localparam int TIMEOUT_DEFAULT = 15;

    // Pipeline register control bundle produced by the hazard unit
    typedef struct packed {
        logic pc_enable;
        logic stall_d;
        logic freeze;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic bubble_w;
    } ctrl_t;

    // True when a producer destination is a real register (not r0) and
    // matches the consumer source register.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand. The MEM-stage result is the newer
// value, so it wins over the WB-stage result when both target the source.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [9:0] regs,
    input  logic [1:0] writes,
    output logic [1:0] sel
);

    logic [4:0] write_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_m;
    logic       reg_write_w;

    assign write_reg_m = regs[9:5];
    assign write_reg_w = regs[4:0];
    assign reg_write_m = writes[1];
    assign reg_write_w = writes[0];

    // Pick the youngest in-flight producer of the source register
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && reg_match(write_reg_m, src)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && reg_match(write_reg_w, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush and data-memory wait handling with a timeout into a sticky error
// state. Also keeps a saturating count of stalled fetch cycles.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [4:0]  Rs_E,
    input  logic [4:0]  Rt_E,
    input  logic [4:0]  WriteReg_E,
    input  logic [4:0]  WriteReg_M,
    input  logic [4:0]  WriteReg_W,
    input  logic        RegWrite_M,
    input  logic        RegWrite_W,
    input  logic        Load_E,
    input  logic        MemReq_M,
    input  logic        MemReady,
    input  logic        BranchTaken_M,
    output logic        PCEnable,
    output logic        StallD,
    output logic        Freeze,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        BubbleW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [31:0] StallCount,
    output logic        MemTimeout
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        mem_wait;
    logic        load_use;
    logic [1:0]  fwd_a_raw;
    logic [1:0]  fwd_b_raw;
    ctrl_t       ctrl;

    assign mem_wait = MemReq_M & ~MemReady;
    assign load_use = Load_E & (reg_match(WriteReg_E, Rs_D) | reg_match(WriteReg_E, Rt_D));

    fwd_sel u_fwd_a (
        .src    (Rs_E),
        .regs   ({WriteReg_M, WriteReg_W}),
        .writes ({RegWrite_M, RegWrite_W}),
        .sel    (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .src    (Rt_E),
        .regs   ({WriteReg_M, WriteReg_W}),
        .writes ({RegWrite_M, RegWrite_W}),
        .sel    (fwd_b_raw)
    );

    // Forwarding is suppressed while the pipeline is held in reset
    always_comb begin
        ForwardAE = fwd_a_raw;
        ForwardBE = fwd_b_raw;
        if (RESET) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end
    end

    // Pipeline control by priority: reset, error/memory wait, branch, load-use.
    // A branch seen during a wait is simply held in EX/MEM by the freeze and
    // takes effect on the first non-wait cycle, so it flushes only once.
    always_comb begin
        ctrl = '0;
        ctrl.pc_enable = 1'b1;
        if (RESET) begin
            ctrl.pc_enable = 1'b0;
            ctrl.flush_d   = 1'b1;
            ctrl.flush_e   = 1'b1;
            ctrl.flush_m   = 1'b1;
            ctrl.bubble_w  = 1'b1;
        end else if ((state_q == ST_ERROR) || mem_wait) begin
            ctrl.pc_enable = 1'b0;
            ctrl.stall_d   = 1'b1;
            ctrl.freeze    = 1'b1;
            ctrl.bubble_w  = 1'b1;
        end else if (BranchTaken_M) begin
            ctrl.flush_d   = 1'b1;
            ctrl.flush_e   = 1'b1;
            ctrl.flush_m   = 1'b1;
        end else if (load_use) begin
            ctrl.pc_enable = 1'b0;
            ctrl.stall_d   = 1'b1;
            ctrl.flush_e   = 1'b1;
        end
    end

    assign PCEnable = ctrl.pc_enable;
    assign StallD   = ctrl.stall_d;
    assign Freeze   = ctrl.freeze;
    assign FlushD   = ctrl.flush_d;
    assign FlushE   = ctrl.flush_e;
    assign FlushM   = ctrl.flush_m;
    assign BubbleW  = ctrl.bubble_w;

    // Memory-wait supervisor: tracks the current run of wait cycles and
    // drops into ERROR once the run exceeds the tolerated length
    always_comb begin
        state_d = state_q;
        if (RESET) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!mem_wait) begin
                        state_d = ST_RUN;
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Consecutive wait-cycle counter, held at all-ones rather than wrapping
    always_comb begin
        wait_cnt_d = 4'd0;
        if (!RESET && mem_wait) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end
    end

    // Saturating count of fetch-stalled cycles; the error state is excluded
    // because nothing is making progress there anyway
    always_comb begin
        stall_count_d = stall_count_q;
        if (RESET) begin
            stall_count_d = 32'd0;
        end else if (!ctrl.pc_enable && (state_q != ST_ERROR) &&
                     (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Sticky timeout flag, raised on the same edge that enters ERROR
    always_comb begin
        mem_timeout_d = mem_timeout_q;
        if (RESET) begin
            mem_timeout_d = 1'b0;
        end else if (state_d == ST_ERROR) begin
            mem_timeout_d = 1'b1;
        end
    end

    // State registers; reset is folded into the next-state logic above
    always_ff @(posedge CLK) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        stall_count_q <= stall_count_d;
        mem_timeout_q <= mem_timeout_d;
    end

    assign StallCount = stall_count_q;
    assign MemTimeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs_d;
        logic [4:0] rt_d;
        logic [4:0] rs_e;
        logic [4:0] rt_e;
        logic [4:0] wr_e;
        logic [4:0] wr_m;
        logic [4:0] wr_w;
        logic       rw_m;
        logic       rw_w;
        logic       load_e;
        logic       memreq;
        logic       memready;
        logic       branch;
    } stim_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic        RegWrite_M, RegWrite_W, Load_E, MemReq_M, MemReady, BranchTaken_M;
    logic        PCEnable, StallD, Freeze, FlushD, FlushE, FlushM, BubbleW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCount;
    logic        MemTimeout;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Behavioural model state
    stim_t  cur;
    int     wait_run;
    bit     in_error;
    longint stall_model;
    bit     timeout_model;

    logic       exp_pc_en, exp_stall_d, exp_freeze, exp_flush_d, exp_flush_e, exp_flush_m, exp_bubble_w;
    logic [1:0] exp_fwd_a, exp_fwd_b;
    logic       wait_now;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Rs_D          (Rs_D),
        .Rt_D          (Rt_D),
        .Rs_E          (Rs_E),
        .Rt_E          (Rt_E),
        .WriteReg_E    (WriteReg_E),
        .WriteReg_M    (WriteReg_M),
        .WriteReg_W    (WriteReg_W),
        .RegWrite_M    (RegWrite_M),
        .RegWrite_W    (RegWrite_W),
        .Load_E        (Load_E),
        .MemReq_M      (MemReq_M),
        .MemReady      (MemReady),
        .BranchTaken_M (BranchTaken_M),
        .PCEnable      (PCEnable),
        .StallD        (StallD),
        .Freeze        (Freeze),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .FlushM        (FlushM),
        .BubbleW       (BubbleW),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .StallCount    (StallCount),
        .MemTimeout    (MemTimeout)
    );

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        s.memready = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] fwdRef(input logic [4:0] src, input stim_t s);
        if (s.rw_m && s.wr_m != 5'd0 && s.wr_m == src) return 2'b10;
        if (s.rw_w && s.wr_w != 5'd0 && s.wr_w == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected outputs for the current inputs and model state
    task automatic computeExpected();
        logic lu;
        wait_now = cur.memreq && !cur.memready;
        lu = cur.load_e && cur.wr_e != 5'd0 && (cur.wr_e == cur.rs_d || cur.wr_e == cur.rt_d);
        exp_pc_en = 1'b1; exp_stall_d = 1'b0; exp_freeze = 1'b0;
        exp_flush_d = 1'b0; exp_flush_e = 1'b0; exp_flush_m = 1'b0; exp_bubble_w = 1'b0;
        exp_fwd_a = 2'b00; exp_fwd_b = 2'b00;
        if (cur.reset) begin
            exp_pc_en = 1'b0; exp_flush_d = 1'b1; exp_flush_e = 1'b1; exp_flush_m = 1'b1; exp_bubble_w = 1'b1;
        end else begin
            exp_fwd_a = fwdRef(cur.rs_e, cur);
            exp_fwd_b = fwdRef(cur.rt_e, cur);
            if (in_error || wait_now) begin
                exp_pc_en = 1'b0; exp_stall_d = 1'b1; exp_freeze = 1'b1; exp_bubble_w = 1'b1;
            end else if (cur.branch) begin
                exp_flush_d = 1'b1; exp_flush_e = 1'b1; exp_flush_m = 1'b1;
            end else if (lu) begin
                exp_pc_en = 1'b0; exp_stall_d = 1'b1; exp_flush_e = 1'b1;
            end
        end
    endtask

    // Effect of the coming rising edge on the model
    task automatic updateModel();
        if (cur.reset) begin
            wait_run = 0; in_error = 0; stall_model = 0; timeout_model = 0;
        end else begin
            if (!exp_pc_en && !in_error && stall_model < 64'hFFFF_FFFF) stall_model++;
            if (!in_error) begin
                if (wait_now) begin
                    wait_run++;
                    if (wait_run > TIMEOUT) begin
                        in_error = 1; timeout_model = 1;
                    end
                end else begin
                    wait_run = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("PCEnable",   PCEnable,   exp_pc_en);
        checkValue("StallD",     StallD,     exp_stall_d);
        checkValue("Freeze",     Freeze,     exp_freeze);
        checkValue("FlushD",     FlushD,     exp_flush_d);
        checkValue("FlushE",     FlushE,     exp_flush_e);
        checkValue("FlushM",     FlushM,     exp_flush_m);
        checkValue("BubbleW",    BubbleW,    exp_bubble_w);
        checkValue("ForwardAE",  ForwardAE,  exp_fwd_a);
        checkValue("ForwardBE",  ForwardBE,  exp_fwd_b);
        checkValue("StallCount", StallCount, stall_model[31:0]);
        checkValue("MemTimeout", MemTimeout, timeout_model);
    endtask

    // Drive one cycle of inputs mid-period and compare against the model
    task automatic applyStimulus(input stim_t s);
        @(negedge CLK);
        cur = s;
        RESET = s.reset; Rs_D = s.rs_d; Rt_D = s.rt_d; Rs_E = s.rs_e; Rt_E = s.rt_e;
        WriteReg_E = s.wr_e; WriteReg_M = s.wr_m; WriteReg_W = s.wr_w;
        RegWrite_M = s.rw_m; RegWrite_W = s.rw_w; Load_E = s.load_e;
        MemReq_M = s.memreq; MemReady = s.memready; BranchTaken_M = s.branch;
        #1;
        computeExpected();
        checkOutput();
    endtask

    task automatic finishCycle();
        @(posedge CLK);
        updateModel();
    endtask

    task automatic runCycle(input stim_t s);
        applyStimulus(s);
        finishCycle();
    endtask

    initial begin
        stim_t s;
        RESET = 1'b1; Rs_D = '0; Rt_D = '0; Rs_E = '0; Rt_E = '0; WriteReg_E = '0; WriteReg_M = '0;
        WriteReg_W = '0; RegWrite_M = 0; RegWrite_W = 0; Load_E = 0; MemReq_M = 0; MemReady = 1; BranchTaken_M = 0;
        repeat (2) @(posedge CLK);
        wait_run = 0; in_error = 0; stall_model = 0; timeout_model = 0;
        $display("[TB] start");

        // Reset state, with forwarding-eligible inputs present
        s = idleStim(); s.reset = 1; s.rs_e = 5; s.wr_m = 5; s.rw_m = 1;
        applyStimulus(s);
        checkValue("rst_pcen", PCEnable, 0);
        checkValue("rst_fwd", ForwardAE, 2'b00);
        checkValue("rst_flushd", FlushD, 1);
        finishCycle();

        // Forwarding: MEM over WB, then WB, then r0 never forwards
        s = idleStim(); s.rs_e = 5; s.rt_e = 5; s.wr_m = 5; s.rw_m = 1; s.wr_w = 5; s.rw_w = 1;
        applyStimulus(s); checkValue("fwd_mem", ForwardAE, 2'b10); checkValue("fwd_mem_b", ForwardBE, 2'b10); finishCycle();
        s.wr_m = 0;
        applyStimulus(s); checkValue("fwd_wb", ForwardAE, 2'b01); finishCycle();
        s.rs_e = 0;
        applyStimulus(s); checkValue("fwd_r0", ForwardAE, 2'b00); finishCycle();

        // Load-use: one stall cycle
        s = idleStim(); s.load_e = 1; s.wr_e = 8; s.rt_d = 8;
        applyStimulus(s);
        checkValue("lu_pcen", PCEnable, 0); checkValue("lu_stalld", StallD, 1); checkValue("lu_flushe", FlushE, 1);
        finishCycle();
        applyStimulus(idleStim());
        checkValue("lu_count", StallCount, 1); checkValue("lu_release", PCEnable, 1);
        finishCycle();

        // Branch without wait
        s = idleStim(); s.branch = 1;
        applyStimulus(s);
        checkValue("br_flushd", FlushD, 1); checkValue("br_flushm", FlushM, 1); checkValue("br_pcen", PCEnable, 1);
        finishCycle();
        runCycle(idleStim());

        // Branch held behind a 3-cycle memory wait, then a single flush
        s = idleStim(); s.branch = 1; s.memreq = 1; s.memready = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkValue("brw_freeze", Freeze, 1); checkValue("brw_noflush", FlushD, 0);
            finishCycle();
        end
        s.memready = 1;
        applyStimulus(s);
        checkValue("brw_flush", FlushD, 1); checkValue("brw_unfreeze", Freeze, 0); checkValue("brw_count", StallCount, 4);
        finishCycle();
        applyStimulus(idleStim()); checkValue("brw_once", FlushD, 0); finishCycle();

        // Timeout: 17 cycles of unanswered memory request
        s = idleStim(); s.reset = 1; runCycle(s);
        s = idleStim(); s.memreq = 1; s.memready = 0;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(s);
            if (i == 16) checkValue("to_not_yet", MemTimeout, 0);
            if (i == 17) begin
                checkValue("to_flag", MemTimeout, 1);
                checkValue("to_count", StallCount, 16);
            end
            finishCycle();
        end
        s.memready = 1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            checkValue("err_stuck", PCEnable, 0); checkValue("err_count", StallCount, 16);
            finishCycle();
        end
        s = idleStim(); s.reset = 1; runCycle(s);
        applyStimulus(idleStim());
        checkValue("post_rst_flag", MemTimeout, 0); checkValue("post_rst_count", StallCount, 0);
        checkValue("post_rst_run", PCEnable, 1);
        finishCycle();

        // Random traffic over a small register set for frequent collisions
        for (int n = 0; n < 400; n++) begin
            s.reset    = ($urandom_range(0, 49) == 0);
            s.rs_d     = 5'($urandom_range(0, 3));
            s.rt_d     = 5'($urandom_range(0, 3));
            s.rs_e     = 5'($urandom_range(0, 3));
            s.rt_e     = 5'($urandom_range(0, 3));
            s.wr_e     = 5'($urandom_range(0, 3));
            s.wr_m     = 5'($urandom_range(0, 3));
            s.wr_w     = 5'($urandom_range(0, 3));
            s.rw_m     = 1'($urandom_range(0, 1));
            s.rw_w     = 1'($urandom_range(0, 1));
            s.load_e   = 1'($urandom_range(0, 1));
            s.memreq   = 1'($urandom_range(0, 1));
            s.memready = ($urandom_range(0, 3) != 0);
            s.branch   = ($urandom_range(0, 3) == 0);
            runCycle(s);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
